// File: rtl/switch_inport_pkg.sv
// Shared definitions for the board input path: debounce FSM encoding and
// the bit positions of the buttons and switches.
package switch_inport_pkg;

  typedef logic [1:0] dbnc_state_t;

  localparam dbnc_state_t DB_IDLE         = 2'd0;
  localparam dbnc_state_t DB_PRESS_WAIT   = 2'd1;
  localparam dbnc_state_t DB_HELD         = 2'd2;
  localparam dbnc_state_t DB_RELEASE_WAIT = 2'd3;

  localparam int unsigned BTN_RUN     = 0;
  localparam int unsigned BTN_LOAD    = 1;
  localparam int unsigned SW_SEL_BIT  = 9;
  localparam int unsigned SW_DATA_MSB = 8;

endpackage

// File: rtl/switch_inport_capture_button_debouncer.sv
// One push button: synchroniser chain plus a four-state debouncer that emits
// a single-cycle pulse once a press has been stable long enough.
module button_debouncer
  import switch_inport_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic press_pulse,
  output logic level
);

  localparam int unsigned Stages = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int unsigned CntW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [Stages-1:0] sync_q, sync_d;
  dbnc_state_t       state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              pressed;

  // Chain presets to 1 so a reset looks like a released button.
  assign sync_d  = {sync_q[Stages-2:0], raw_n};
  assign pressed = ~sync_q[Stages-1];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    press_pulse = 1'b0;
    case (state_q)
      DB_IDLE: begin
        if (pressed) begin
          state_d = DB_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      DB_PRESS_WAIT: begin
        if (!pressed) begin
          state_d = DB_IDLE;
        end else if (cnt_q == CntLast) begin
          state_d     = DB_HELD;
          press_pulse = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DB_HELD: begin
        if (!pressed) begin
          state_d = DB_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      DB_RELEASE_WAIT: begin
        if (pressed) begin
          state_d = DB_HELD;
        end else if (cnt_q == CntLast) begin
          state_d = DB_IDLE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = DB_IDLE;
    endcase
  end

  assign level = (state_q == DB_HELD) || (state_q == DB_RELEASE_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '1;
      state_q <= DB_IDLE;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/switch_inport_capture.sv
// Board input path: debounced run/load buttons and synchronised switches feed
// the two memory-mapped input-port registers with per-port new-data flags.
module switch_inport_capture
  import switch_inport_pkg::*;
#(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       buttons,
  input  logic [9:0]       switches,
  output logic [WIDTH-1:0] inport0,
  output logic [WIDTH-1:0] inport1,
  output logic             inport0_new,
  output logic             inport1_new,
  input  logic             rd_inport0,
  input  logic             rd_inport1,
  output logic             run_pulse
);

  localparam int unsigned Stages = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [Stages-1:0][9:0] sw_sync_q, sw_sync_d;
  logic [WIDTH-1:0]       in0_q, in0_d, in1_q, in1_d;
  logic                   new0_q, new0_d, new1_q, new1_d;
  logic                   run_pulse_q, run_pulse_d;
  logic [1:0]             press;
  logic [1:0]             btn_level;
  logic [9:0]             sw_now;
  logic                   load0, load1;
  logic [WIDTH-1:0]       load_val;
  logic                   unused_level;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (Stages)
  ) u_dbnc_run (
    .clk        (clk),
    .rst        (rst),
    .raw_n      (buttons[BTN_RUN]),
    .press_pulse(press[BTN_RUN]),
    .level      (btn_level[BTN_RUN])
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (Stages)
  ) u_dbnc_load (
    .clk        (clk),
    .rst        (rst),
    .raw_n      (buttons[BTN_LOAD]),
    .press_pulse(press[BTN_LOAD]),
    .level      (btn_level[BTN_LOAD])
  );

  assign unused_level = ^btn_level;

  assign sw_sync_d = {sw_sync_q[Stages-2:0], switches};
  assign sw_now    = sw_sync_q[Stages-1];

  always_comb begin
    load0       = press[BTN_LOAD] & ~sw_now[SW_SEL_BIT];
    load1       = press[BTN_LOAD] &  sw_now[SW_SEL_BIT];
    load_val    = WIDTH'(sw_now[SW_DATA_MSB:0]);
    in0_d       = load0 ? load_val : in0_q;
    in1_d       = load1 ? load_val : in1_q;
    // A load in the same cycle as a read keeps the flag set.
    new0_d      = load0 ? 1'b1 : (rd_inport0 ? 1'b0 : new0_q);
    new1_d      = load1 ? 1'b1 : (rd_inport1 ? 1'b0 : new1_q);
    run_pulse_d = press[BTN_RUN];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_sync_q   <= '1;
      in0_q       <= '0;
      in1_q       <= '0;
      new0_q      <= 1'b0;
      new1_q      <= 1'b0;
      run_pulse_q <= 1'b0;
    end else begin
      sw_sync_q   <= sw_sync_d;
      in0_q       <= in0_d;
      in1_q       <= in1_d;
      new0_q      <= new0_d;
      new1_q      <= new1_d;
      run_pulse_q <= run_pulse_d;
    end
  end

  assign inport0     = in0_q;
  assign inport1     = in1_q;
  assign inport0_new = new0_q;
  assign inport1_new = new1_q;
  assign run_pulse   = run_pulse_q;

endmodule

// File: tb/tb_switch_inport_capture.sv
// Bench for switch_inport_capture: directed scenarios plus random button and
// switch activity against a run-length model of the debounce rules.
module tb_switch_inport_capture;

  localparam int unsigned W  = 32;
  localparam int unsigned DC = 4;
  localparam int unsigned SS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    buttons = 2'b11;
  logic [9:0]    switches = '0;
  logic          rd_inport0 = 1'b0;
  logic          rd_inport1 = 1'b0;
  logic [W-1:0]  inport0, inport1;
  logic          inport0_new, inport1_new, run_pulse;

  int n_checks = 0;
  int n_bad    = 0;

  // Reference model state
  logic [1:0]   dly0, dly1;
  logic [9:0]   swd0, swd1;
  bit   [1:0]   lvl;
  int           run_len [2];
  logic [W-1:0] m_in0, m_in1;
  logic         m_new0, m_new1, m_run;

  switch_inport_capture #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(DC),
    .SYNC_STAGES    (SS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .buttons    (buttons),
    .switches   (switches),
    .inport0    (inport0),
    .inport1    (inport1),
    .inport0_new(inport0_new),
    .inport1_new(inport1_new),
    .rd_inport0 (rd_inport0),
    .rd_inport1 (rd_inport1),
    .run_pulse  (run_pulse)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    dly0 = 2'b11; dly1 = 2'b11;
    swd0 = '1;    swd1 = '1;
    lvl = '0;
    run_len[0] = 0; run_len[1] = 0;
    m_in0 = '0; m_in1 = '0;
    m_new0 = 1'b0; m_new1 = 1'b0; m_run = 1'b0;
  endtask

  // A level is accepted once the pressed signal has disagreed with the
  // accepted level for DC+1 consecutive cycles; accepting a press pulses.
  task automatic model_edge();
    bit [1:0] pulse;
    bit       pb;
    pulse = '0;
    for (int b = 0; b < 2; b++) begin
      pb = ~dly1[b];
      if (pb != lvl[b]) run_len[b]++;
      else run_len[b] = 0;
      if (run_len[b] == DC + 1) begin
        if (!lvl[b]) pulse[b] = 1'b1;
        lvl[b] = ~lvl[b];
        run_len[b] = 0;
      end
    end
    m_run = pulse[0];
    if (pulse[1] && !swd1[9]) begin
      m_in0 = W'(swd1[8:0]);
      m_new0 = 1'b1;
    end else if (rd_inport0) begin
      m_new0 = 1'b0;
    end
    if (pulse[1] && swd1[9]) begin
      m_in1 = W'(swd1[8:0]);
      m_new1 = 1'b1;
    end else if (rd_inport1) begin
      m_new1 = 1'b0;
    end
    dly1 = dly0; dly0 = buttons;
    swd1 = swd0; swd0 = switches;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    @(negedge clk);
    check_eq("m_in0", inport0, m_in0);
    check_eq("m_in1", inport1, m_in1);
    check_eq("m_new0", inport0_new, m_new0);
    check_eq("m_new1", inport1_new, m_new1);
    check_eq("m_run", run_pulse, m_run);
  endtask

  // Called at a negedge; outputs must clear before the next rising edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_eq("rst_in0", inport0, 0);
    check_eq("rst_in1", inport1, 0);
    check_eq("rst_new0", inport0_new, 0);
    check_eq("rst_new1", inport1_new, 0);
    check_eq("rst_run", run_pulse, 0);
    model_reset();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int runs;
    model_reset();
    @(negedge clk);
    do_reset();
    repeat (3) step();

    // Load INPORT0 with 0x0AB, read mid-hold to prove a single load
    switches = 10'h0AB;
    buttons  = 2'b01;
    for (int i = 1; i <= 10; i++) begin
      if (i == 8) rd_inport0 = 1'b1;
      step();
      rd_inport0 = 1'b0;
      if (i == 6) check_eq("ld0_early", inport0, 0);
      if (i == 7) begin
        check_eq("ld0_val", inport0, 32'h0000_00AB);
        check_eq("ld0_new", inport0_new, 1);
        check_eq("ld0_in1", inport1, 0);
      end
      if (i == 10) check_eq("ld0_once", inport0_new, 0);
    end
    buttons = 2'b11;
    repeat (12) step();
    check_eq("ld0_after", inport0_new, 0);

    // Load INPORT1 with 0x1FF, then read it
    switches = 10'h3FF;
    buttons  = 2'b01;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 7) begin
        check_eq("ld1_val", inport1, 32'h0000_01FF);
        check_eq("ld1_new", inport1_new, 1);
        check_eq("ld1_in0", inport0, 32'h0000_00AB);
      end
    end
    buttons = 2'b11;
    repeat (12) step();
    rd_inport1 = 1'b1;
    step();
    rd_inport1 = 1'b0;
    check_eq("rd1_new", inport1_new, 0);
    check_eq("rd1_val", inport1, 32'h0000_01FF);

    // Bounce: short presses never load
    switches = 10'h0CC;
    repeat (5) begin
      buttons = 2'b01;
      repeat (3) step();
      buttons = 2'b11;
      step();
    end
    repeat (10) step();
    check_eq("bnc_in0", inport0, 32'h0000_00AB);
    check_eq("bnc_in1", inport1, 32'h0000_01FF);
    check_eq("bnc_new0", inport0_new, 0);
    check_eq("bnc_new1", inport1_new, 0);

    // Release glitch while held must not give a second load
    switches = 10'h012;
    buttons  = 2'b01;
    for (int i = 1; i <= 10; i++) begin
      if (i == 8) rd_inport0 = 1'b1;
      step();
      rd_inport0 = 1'b0;
    end
    check_eq("gl_val", inport0, 32'h0000_0012);
    buttons = 2'b11;
    repeat (2) step();
    buttons = 2'b01;
    repeat (10) step();
    check_eq("gl_new", inport0_new, 0);
    buttons = 2'b11;
    repeat (12) step();

    // Read collides with a load of INPORT0: load wins
    switches = 10'h055;
    buttons  = 2'b01;
    for (int i = 1; i <= 10; i++) begin
      if (i == 7) rd_inport0 = 1'b1;
      step();
      rd_inport0 = 1'b0;
      if (i == 7) begin
        check_eq("col_val", inport0, 32'h0000_0055);
        check_eq("col_new", inport0_new, 1);
      end
    end
    buttons = 2'b11;
    repeat (12) step();

    // Reset mid-debounce, release reset with the load button still held
    buttons = 2'b01;
    repeat (3) step();
    do_reset();
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i <= 6) begin
        check_eq("rh_in0", inport0, 0);
        check_eq("rh_new0", inport0_new, 0);
      end else begin
        check_eq("rh_load", inport0, 32'h0000_0055);
      end
    end
    buttons = 2'b11;
    repeat (12) step();

    // Run and load pressed together; run held for 100 cycles
    switches = 10'h2A5;
    buttons  = 2'b00;
    runs = 0;
    for (int i = 1; i <= 100; i++) begin
      if (i == 11) buttons = 2'b10;
      step();
      if (run_pulse) runs++;
      if (i == 7) begin
        check_eq("rl_run", run_pulse, 1);
        check_eq("rl_val", inport1, 32'h0000_00A5);
        check_eq("rl_new", inport1_new, 1);
      end
    end
    check_eq("rl_runs", runs, 1);
    buttons = 2'b11;
    repeat (12) step();

    // Random activity against the model
    for (int s = 0; s < 300; s++) begin
      buttons  = 2'($urandom_range(0, 3));
      switches = 10'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        do_reset();
      end else begin
        repeat ($urandom_range(1, 12)) begin
          rd_inport0 = ($urandom_range(0, 3) == 0);
          rd_inport1 = ($urandom_range(0, 3) == 0);
          step();
        end
        rd_inport0 = 1'b0;
        rd_inport1 = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
